// File: rtl/sr_driver_if.sv
// -----------------------------------------------------------------------------
// sr_driver_if
// Request handshake between a requester and the sr_driver pulse generator.
//
// Signals:
//   req_valid  requester -> driver  level-change request valid
//   req_level  requester -> driver  requested latch level
//   req_ready  driver -> requester  request accepted when req_valid & req_ready
//
// Modports:
//   master  requester side (drives valid/level, observes ready)
//   slave   driver side    (observes valid/level, drives ready)
// -----------------------------------------------------------------------------
interface sr_driver_if;
    logic req_valid;
    logic req_level;
    logic req_ready;

    modport master (
        output req_valid,
        output req_level,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_level,
        output req_ready
    );
endinterface

// File: rtl/sr_driver.sv
// -----------------------------------------------------------------------------
// sr_driver
// Drives an external SR latch with a set or reset pulse of PULSE_W clk cycles
// whenever a request asks for a level different from the last confirmed one,
// then waits for the synchronised latch output to confirm the new level.
//
// Parameters:
//   Rval       latch level assumed after reset
//   set_inv    1: set output is active-low
//   reset_inv  1: reset output is active-low
//   PULSE_W    pulse width in clk cycles (1..15)
//   TIMEOUT    WAIT-state cycle limit (1..255), used only with the macro below
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous reset, active-high
//   req        sr_driver_if.slave (req_valid, req_level, req_ready)
//   set        set pulse to the latch, polarity per set_inv
//   reset      reset pulse to the latch, polarity per reset_inv
//   fb         latch output, asynchronous to clk
//   level      last confirmed latch level
//   busy       high in any state other than IDLE
//   err        sticky timeout flag
//
// Build option:
//   SR_DRIVER_TIMEOUT_EN  when defined, a WAIT lasting TIMEOUT cycles without
//                         confirmation enters ERROR (sticky err, left only by
//                         rst). When undefined, WAIT persists until confirmed,
//                         err is tied low and no timeout counter exists.
// -----------------------------------------------------------------------------
module sr_driver #(
    parameter logic Rval      = 1'b0,
    parameter logic set_inv   = 1'b0,
    parameter logic reset_inv = 1'b0,
    parameter int   PULSE_W   = 2,
    parameter int   TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    sr_driver_if.slave  req,
    output logic        set,
    output logic        reset,
    input  logic        fb,
    output logic        level,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    // Last pulse-counter value before leaving PULSE
    localparam logic [3:0] PW_LAST = 4'(PULSE_W - 1);

    state_t     state_q, state_d;
    logic       fb_meta_q;
    logic       fb_s_q;
    logic       target_q, target_d;
    logic       level_q, level_d;
    logic [3:0] pcnt_q, pcnt_d;
    logic       set_q, set_d;
    logic       reset_q, reset_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

`ifdef SR_DRIVER_TIMEOUT_EN
    // Last timeout-counter value before WAIT gives up
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tcnt_q, tcnt_d;
`endif

    // req_ready is combinational so it drops in the very cycle rst is raised
    assign req.req_ready = (state_q == ST_IDLE) & ~rst;
    assign set   = set_q;
    assign reset = reset_q;
    assign level = level_q;
    assign busy  = busy_q;
    assign err   = err_q;

    // Two-flop synchroniser for the asynchronous latch feedback
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_meta_q <= Rval;
            fb_s_q    <= Rval;
        end else begin
            fb_meta_q <= fb;
            fb_s_q    <= fb_meta_q;
        end
    end

    // State, datapath and registered-output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            target_q <= Rval;
            level_q  <= Rval;
            pcnt_q   <= 4'd0;
            set_q    <= set_inv;
            reset_q  <= reset_inv;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            level_q  <= level_d;
            pcnt_q   <= pcnt_d;
            set_q    <= set_d;
            reset_q  <= reset_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

`ifdef SR_DRIVER_TIMEOUT_EN
    // WAIT-duration counter flop
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= 8'd0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`endif

    // Next-state, target/level capture and counter update
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        level_d  = level_q;
        case (state_q)
            ST_IDLE: begin
                // Same-level requests are accepted as a no-op; fb is ignored here
                if (req.req_valid && (req.req_level != level_q)) begin
                    state_d  = ST_PULSE;
                    target_d = req.req_level;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (pcnt_q == PW_LAST) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_WAIT: begin
                if (fb_s_q == target_q) begin
                    state_d = ST_IDLE;
                    level_d = target_q;
`ifdef SR_DRIVER_TIMEOUT_EN
                end else if (tcnt_q == TO_LAST) begin
                    state_d = ST_ERROR;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counters restart on every state change and only advance in their state
        if (state_d != state_q) begin
            pcnt_d = 4'd0;
        end else if (state_q == ST_PULSE) begin
            pcnt_d = pcnt_q + 4'd1;
        end else begin
            pcnt_d = pcnt_q;
        end
    end

`ifdef SR_DRIVER_TIMEOUT_EN
    // Timeout counter: counts cycles spent in WAIT
    always_comb begin
        if (state_d != state_q) begin
            tcnt_d = 8'd0;
        end else if (state_q == ST_WAIT) begin
            tcnt_d = tcnt_q + 8'd1;
        end else begin
            tcnt_d = tcnt_q;
        end
    end
`endif

    // Output decode from the next state so the output flops track the state
    // flop; set and reset decode mutually exclusive target values
    always_comb begin
        if ((state_d == ST_PULSE) && target_d) begin
            set_d = ~set_inv;
        end else begin
            set_d = set_inv;
        end
        if ((state_d == ST_PULSE) && !target_d) begin
            reset_d = ~reset_inv;
        end else begin
            reset_d = reset_inv;
        end
        busy_d = (state_d != ST_IDLE);
`ifdef SR_DRIVER_TIMEOUT_EN
        err_d = (state_d == ST_ERROR);
`else
        err_d = 1'b0;
`endif
    end

endmodule

// File: tb/tb_sr_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_driver
// Directed self-checking bench for sr_driver. Two instances: u0 with default
// parameters and u1 with active-low set/reset. Each drives a behavioural SR
// latch whose output is fed back as fb; u0's feedback can be forced low to
// emulate a stuck latch. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_sr_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic model_clr;
    logic stuck0;

    sr_driver_if if0();
    sr_driver_if if1();

    logic set0, reset0, fb0, level0, busy0, err0;
    logic set1, reset1, fb1, level1, busy1, err1;
    logic q0, q1;

    int errors = 0;
    int checks = 0;

    sr_driver u0 (
        .clk   (clk),
        .rst   (rst),
        .req   (if0),
        .set   (set0),
        .reset (reset0),
        .fb    (fb0),
        .level (level0),
        .busy  (busy0),
        .err   (err0)
    );

    sr_driver #(
        .set_inv   (1'b1),
        .reset_inv (1'b1)
    ) u1 (
        .clk   (clk),
        .rst   (rst),
        .req   (if1),
        .set   (set1),
        .reset (reset1),
        .fb    (fb1),
        .level (level1),
        .busy  (busy1),
        .err   (err1)
    );

    // Behavioural SR latch driven by u0 (active-high pulses)
    always_latch begin
        if (model_clr) begin
            q0 <= 1'b0;
        end else if (set0) begin
            q0 <= 1'b1;
        end else if (reset0) begin
            q0 <= 1'b0;
        end
    end

    // Behavioural SR latch driven by u1 (active-low pulses)
    always_latch begin
        if (model_clr) begin
            q1 <= 1'b0;
        end else if (!set1) begin
            q1 <= 1'b1;
        end else if (!reset1) begin
            q1 <= 1'b0;
        end
    end

    assign fb0 = stuck0 ? 1'b0 : q0;
    assign fb1 = q1;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check that no instance ever has
    // both pulses active
    task automatic tick();
        @(negedge clk);
        check("mutex_u0", set0 & reset0, 1'b0);
        check("mutex_u1", (~set1) & (~reset1), 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        model_clr = 1'b1;
        stuck0 = 1'b0;
        if0.req_valid = 1'b0;
        if0.req_level = 1'b0;
        if1.req_valid = 1'b0;
        if1.req_level = 1'b0;
        tick();
        tick();
        model_clr = 1'b0;

        // Reset state, rst still high
        check("rst_ready0", if0.req_ready, 1'b0);
        check("rst_set0",   set0,   1'b0);
        check("rst_reset0", reset0, 1'b0);
        check("rst_level0", level0, 1'b0);
        check("rst_busy0",  busy0,  1'b0);
        check("rst_err0",   err0,   1'b0);
        check("rst_set1",   set1,   1'b1);
        check("rst_reset1", reset1, 1'b1);
        check("rst_ready1", if1.req_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", if0.req_ready, 1'b1);

        // Request level 1: set for two cycles, confirmation after sync + WAIT
        if0.req_valid = 1'b1;
        if0.req_level = 1'b1;
        tick();
        if0.req_valid = 1'b0;
        check("up_set_c1",   set0,   1'b1);
        check("up_reset_c1", reset0, 1'b0);
        check("up_busy_c1",  busy0,  1'b1);
        check("up_ready_c1", if0.req_ready, 1'b0);
        check("up_level_c1", level0, 1'b0);
        tick();
        check("up_set_c2",   set0,   1'b1);
        check("up_level_c2", level0, 1'b0);
        tick();
        check("up_set_c3",   set0,   1'b0);
        check("up_busy_c3",  busy0,  1'b1);
        check("up_level_c3", level0, 1'b0);
        tick();
        check("up_level_c4", level0, 1'b1);
        check("up_busy_c4",  busy0,  1'b0);
        check("up_ready_c4", if0.req_ready, 1'b1);

        // Same-level request is a zero-cycle no-op, even when held
        if0.req_valid = 1'b1;
        if0.req_level = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("noop_set",   set0,   1'b0);
            check("noop_reset", reset0, 1'b0);
            check("noop_busy",  busy0,  1'b0);
            check("noop_ready", if0.req_ready, 1'b1);
            check("noop_level", level0, 1'b1);
        end

        // Request 0, then hold a request for 1 while busy: it must not be
        // taken until the driver is back in IDLE
        if0.req_level = 1'b0;
        tick();
        if0.req_level = 1'b1;
        check("dn_reset_c1", reset0, 1'b1);
        check("dn_set_c1",   set0,   1'b0);
        check("dn_busy_c1",  busy0,  1'b1);
        tick();
        check("dn_reset_c2", reset0, 1'b1);
        tick();
        check("dn_reset_c3", reset0, 1'b0);
        tick();
        check("dn_level",    level0, 1'b0);
        check("dn_busy",     busy0,  1'b0);
        check("dn_ready",    if0.req_ready, 1'b1);
        check("held_no_set", set0,   1'b0);
        tick();
        if0.req_valid = 1'b0;
        check("held_set",    set0,   1'b1);
        check("held_busy",   busy0,  1'b1);
        tick();
        tick();
        tick();
        check("held_level",  level0, 1'b1);
        check("held_idle",   busy0,  1'b0);

        // rst during the second PULSE cycle aborts the operation
        if0.req_valid = 1'b1;
        if0.req_level = 1'b0;
        tick();
        if0.req_valid = 1'b0;
        check("ab_reset_c1", reset0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        check("ab_reset_off", reset0, 1'b0);
        check("ab_set_off",   set0,   1'b0);
        check("ab_level",     level0, 1'b0);
        check("ab_busy",      busy0,  1'b0);
        check("ab_ready_rst", if0.req_ready, 1'b0);
        rst = 1'b0;
        if0.req_valid = 1'b1;
        if0.req_level = 1'b1;
        #1;
        check("ab_ready_after", if0.req_ready, 1'b1);
        tick();
        if0.req_valid = 1'b0;
        check("ab_new_set",  set0,   1'b1);
        check("ab_new_busy", busy0,  1'b1);
        tick();
        tick();
        tick();
        check("ab_new_level", level0, 1'b1);
        check("ab_new_idle",  busy0,  1'b0);

        // Feedback stuck at 0 while requesting 1
        stuck0 = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("st_level_rst", level0, 1'b0);
        if0.req_valid = 1'b1;
        if0.req_level = 1'b1;
        tick();
        if0.req_valid = 1'b0;
        tick();
        tick();
        check("st_wait_busy", busy0, 1'b1);
        check("st_wait_set",  set0,  1'b0);
        repeat (15) tick();
        check("st_err_w15",  err0,  1'b0);
        check("st_busy_w15", busy0, 1'b1);
        tick();
`ifdef SR_DRIVER_TIMEOUT_EN
        check("to_err",   err0,  1'b1);
        check("to_level", level0, 1'b0);
        check("to_ready", if0.req_ready, 1'b0);
        check("to_busy",  busy0, 1'b1);
        stuck0 = 1'b0;
        repeat (4) tick();
        check("to_err_sticky",   err0,  1'b1);
        check("to_ready_sticky", if0.req_ready, 1'b0);
        check("to_level_kept",   level0, 1'b0);
        check("to_set_off",      set0,  1'b0);
`else
        check("nt_err",   err0,  1'b0);
        check("nt_busy",  busy0, 1'b1);
        check("nt_level", level0, 1'b0);
        stuck0 = 1'b0;
        tick();
        tick();
        check("nt_level_pending", level0, 1'b0);
        tick();
        check("nt_level_conf", level0, 1'b1);
        check("nt_idle",       busy0,  1'b0);
        check("nt_err_low",    err0,   1'b0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_err",  err0,  1'b0);
        check("post_rst_busy", busy0, 1'b0);

        // Active-low instance: request 1 then 0
        if1.req_valid = 1'b1;
        if1.req_level = 1'b1;
        tick();
        if1.req_valid = 1'b0;
        check("inv_set_c1",   set1,   1'b0);
        check("inv_reset_c1", reset1, 1'b1);
        check("inv_busy_c1",  busy1,  1'b1);
        tick();
        check("inv_set_c2",   set1,   1'b0);
        tick();
        check("inv_set_c3",   set1,   1'b1);
        tick();
        check("inv_level_up", level1, 1'b1);
        check("inv_idle_up",  busy1,  1'b0);
        if1.req_valid = 1'b1;
        if1.req_level = 1'b0;
        tick();
        if1.req_valid = 1'b0;
        check("inv_reset_d1", reset1, 1'b0);
        check("inv_set_d1",   set1,   1'b1);
        tick();
        check("inv_reset_d2", reset1, 1'b0);
        tick();
        check("inv_reset_d3", reset1, 1'b1);
        tick();
        check("inv_level_dn", level1, 1'b0);
        check("inv_idle_dn",  busy1,  1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_driver.md
SR_DRIVER -- requirements
Module: sr_driver

Interface
REQ-001 SHALL provide parameter Rval, default 1'b0: latch level assumed after reset.
REQ-002 SHALL provide parameter set_inv, default 1'b0: set output is active-low when 1.
REQ-003 SHALL provide parameter reset_inv, default 1'b0: reset output is active-low when 1.
REQ-004 SHALL provide parameter PULSE_W, default 2: set/reset pulse width in clk cycles, legal range 1..15.
REQ-005 SHALL provide parameter TIMEOUT, default 16: WAIT-state cycle limit, legal range 1..255.
REQ-006 SHALL provide port clk  input  1  sole clock, rising edge.
REQ-007 SHALL provide port rst  input  1  synchronous reset, active-high.
REQ-008 SHALL provide port req_valid  input  1  level-change request valid.
REQ-009 SHALL provide port req_level  input  1  requested latch level.
REQ-010 SHALL provide port req_ready  output  1  request accepted when req_valid & req_ready.
REQ-011 SHALL provide port set  output  1  set pulse to the external sr_latch, polarity per set_inv.
REQ-012 SHALL provide port reset  output  1  reset pulse to the external sr_latch, polarity per reset_inv.
REQ-013 SHALL provide port fb  input  1  latch output o, asynchronous to clk.
REQ-014 SHALL provide port level  output  1  last confirmed latch level.
REQ-015 SHALL provide port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL provide port err  output  1  sticky timeout flag.

Function
REQ-017 SHALL synchronise fb through two flops into fb_s before any use.
REQ-018 SHALL implement states IDLE, PULSE, WAIT, ERROR; req_ready = (state==IDLE) & ~rst.
REQ-019 IDLE, accepted request with req_level==level: no pulse, remain in IDLE, req_ready stays 1 (zero-cycle no-op).
REQ-020 IDLE, accepted request with req_level!=level: latch target=req_level, go to PULSE on that edge.
REQ-021 PULSE: assert set (target=1) or reset (target=0) for exactly PULSE_W cycles, starting the cycle after acceptance, then go to WAIT.
REQ-022 set and reset SHALL never be active in the same cycle, in any state or during reset.
REQ-023 WAIT: both pulses inactive; on the first cycle fb_s==target, level<=target and go to IDLE; req_ready is high the following cycle.
REQ-024 Requests presented while busy SHALL be ignored (not accepted, not queued); req_valid may be held.
REQ-025 Pulse counter SHALL be 4 bits; timeout counter 8 bits; both clear on every state entry; no wrap-around is reachable with legal parameters.
REQ-026 level SHALL change only on WAIT->IDLE confirmation; fb_s changes while in IDLE SHALL be ignored.

Reset
REQ-027 On rst high at a clk edge: state=IDLE, set=set_inv, reset=reset_inv (both inactive), level=Rval, err=0, busy=0, counters=0, synchroniser flops=Rval.
REQ-028 rst in PULSE or WAIT SHALL abort the operation; pulses inactive from the cycle after the reset edge; target discarded.
REQ-029 req_ready SHALL be 0 in every cycle in which rst is high.

Configuration
REQ-030 With macro SR_DRIVER_TIMEOUT_EN defined: TIMEOUT cycles in WAIT without fb_s==target -> ERROR; err=1; level unchanged; pulses inactive; req_ready=0; exit only by rst.
REQ-031 Without SR_DRIVER_TIMEOUT_EN: WAIT persists until fb_s==target; ERROR unreachable; err tied 0; timeout counter not built.

Verification
REQ-032 After rst with Rval=0: req_valid=1, req_level=1 -> set active cycles 1..2 after acceptance (PULSE_W=2), latch model sets, level=1 two cycles after fb rises, then req_ready=1.
REQ-033 level=1, request req_level=1 -> no set/reset activity, req_ready remains 1, busy remains 0.
REQ-034 set_inv=1, reset_inv=1, request 1 then 0 -> set low for PULSE_W cycles, then reset low for PULSE_W cycles; never both low; final level=0.
REQ-035 SR_DRIVER_TIMEOUT_EN, TIMEOUT=16, fb stuck 0, request 1 -> err=1 exactly 16 cycles after WAIT entry, level=0, req_ready=0 until rst.
REQ-036 rst asserted in the 2nd PULSE cycle -> set inactive next cycle, level=Rval, busy=0, and a new request is accepted in the first cycle after rst falls.
